nonce_tx_framer: RTL and testbench
==================================

NONCE_TX_FRAMER -- requirements
Module: nonce_tx_framer

Interface
REQ-001 Parameter DEPTH, default 4: word FIFO depth, power of 2, range 2..16.
REQ-002 Parameter SYNC_BYTE, default 8'hA5: frame header byte.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 word_in  input  32  nonce word to transmit.
REQ-006 word_valid  input  1  word_in is valid this cycle.
REQ-007 word_ready  output  1  FIFO not full; a word is accepted when word_valid&&word_ready.
REQ-008 TxD_start  output  1  one-cycle start pulse to the downstream UART transmitter.
REQ-009 data_out  output  8  byte for the transmitter; stable from TxD_start until TxD_busy falls.
REQ-010 TxD_busy  input  1  transmitter busy; rises one cycle after TxD_start and falls at the end of the frame.
REQ-011 idle  output  1  FIFO empty and FSM in IDLE.
REQ-012 frames_sent  output  16  count of completed frames; wraps at 65535->0.

Function
REQ-013 Frame format: SYNC_BYTE, then word bytes [31:24], [23:16], [15:8], [7:0], in that order.
REQ-014 FSM states: IDLE, LOAD, START, WAIT_HI, WAIT_LO.
REQ-015 IDLE: when the FIFO is non-empty, go to LOAD.
REQ-016 LOAD: pop the FIFO head into the shift register, set byte_idx=0, go to START.
REQ-017 START: drive data_out for byte_idx, assert TxD_start for exactly one cycle only if TxD_busy=0, then go to WAIT_HI.
REQ-018 WAIT_HI: wait for TxD_busy=1, then go to WAIT_LO.
REQ-019 WAIT_HI timeout: if TxD_busy does not rise within 2 cycles, return to START and resend the same byte.
REQ-020 WAIT_LO: on TxD_busy=0, advance to the next byte and go to START; after the last byte, increment frames_sent and go to IDLE.
REQ-021 Minimum gap is 1 cycle between TxD_busy falling and the next TxD_start; TxD_start is never asserted while TxD_busy=1.
REQ-022 FIFO push and pop in the same cycle are both honoured; the count is unchanged.
REQ-023 Push when full is dropped; word_ready=0 in that cycle, and the FIFO contents are unchanged.
REQ-024 FIFO pointers wrap modulo DEPTH.
REQ-025 Latency: the first TxD_start occurs 3 cycles after the accepting cycle when the block is idle.

Reset
REQ-026 rst has priority over all other inputs and clears the FSM to IDLE and empties the FIFO.
REQ-027 Reset output values: TxD_start=0, data_out=0, word_ready=1, idle=1, frames_sent=0.
REQ-028 rst mid-frame abandons the frame without completing the current byte, and no further TxD_start is issued.

Configuration
REQ-029 Macro NONCE_TX_CHECKSUM_EN, when defined, appends a 6th byte after the last word byte: the XOR of the 4 word bytes, excluding SYNC_BYTE.
REQ-030 With NONCE_TX_CHECKSUM_EN defined, frames_sent increments only after the checksum byte completes.
REQ-031 With NONCE_TX_CHECKSUM_EN undefined, frames are 5 bytes and no checksum logic is present.

Structure
REQ-032 Shared package nonce_tx_pkg holds: the FSM state enum, SYNC_BYTE default, FRAME_BYTES (5, or 6 with checksum), and the WAIT_HI timeout constant (2).
REQ-033 The FIFO is the sub-module nonce_word_fifo, with push, pop, full, empty and dout ports; the rest of the logic is inline.

Verification
REQ-034 Bench model: a transmitter that raises TxD_busy 1 cycle after TxD_start and holds it for 10 cycles.
REQ-035 Single word: push 32'hDEADBEEF when idle -> bytes A5, DE, AD, BE, EF; frames_sent=1; idle=1 afterwards. With the checksum macro, one extra byte 8'h22.
REQ-036 Overflow: DEPTH=4, push 6 words back-to-back while the transmitter is stalled busy -> 4 words accepted (the first may already be popped, allowing 5), word_ready=0 on the rejected cycles, and the transmitted order matches acceptance order.
REQ-037 Simultaneous events: push a word in the same cycle the FSM pops with FIFO full -> push accepted and no word lost.
REQ-038 Timeout: transmitter ignores the first TxD_start -> the same byte is re-pulsed after the 2-cycle timeout and the frame completes correctly.
REQ-039 Reset mid-frame: assert rst after the 2nd byte -> all outputs at reset values next cycle; a subsequently pushed 32'h00000001 sends a full fresh frame.
REQ-040 Wrap: preload frames_sent near 16'hFFFF by sending 65536 frames (or force) -> frames_sent wraps to 0.

Source files
------------

// File: rtl/nonce_tx_pkg.sv
// Shared types and constants for the nonce transmit framer.
// NONCE_TX_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
package nonce_tx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

`ifdef NONCE_TX_CHECKSUM_EN
  localparam int FRAME_BYTES = 6;
`else
  localparam int FRAME_BYTES = 5;
`endif

  localparam int WAIT_HI_TIMEOUT = 2;

  // Byte idx of a frame: header, word MSB first, optional checksum.
  function automatic logic [7:0] frame_byte(input logic [31:0] w, input logic [2:0] idx,
                                            input logic [7:0] sync);
    logic [7:0] b;
    case (idx)
      3'd0:    b = sync;
      3'd1:    b = w[31:24];
      3'd2:    b = w[23:16];
      3'd3:    b = w[15:8];
      3'd4:    b = w[7:0];
`ifdef NONCE_TX_CHECKSUM_EN
      3'd5:    b = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nonce_word_fifo.sv
// Word FIFO for the framer; a push while full is honoured only if a pop
// frees the slot in the same cycle.
module nonce_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/nonce_tx_framer.sv
// Buffers 32-bit nonce words and sends each as SYNC_BYTE + 4 bytes (MSB first)
// to a UART transmitter. NONCE_TX_CHECKSUM_EN appends an XOR checksum byte.
module nonce_tx_framer
  import nonce_tx_pkg::*;
#(
  parameter int         DEPTH     = 4,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        TxD_start,
  output logic [7:0]  data_out,
  input  logic        TxD_busy,
  output logic        idle,
  output logic [15:0] frames_sent
);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
  localparam logic [1:0] TO_LAST  = 2'(WAIT_HI_TIMEOUT - 1);

  state_e      r_state;
  logic [31:0] r_word;
  logic [2:0]  r_byte_idx;
  logic [1:0]  r_to_cnt;
  logic        r_txd_start;
  logic [7:0]  r_data_out;
  logic [15:0] r_frames_sent;

  logic        w_pop;
  logic        w_push;
  logic        w_full;
  logic        w_empty;
  logic [31:0] w_fifo_dout;
  logic [2:0]  w_next_idx;

  // The pop slot is known from state alone, so a full FIFO can still take a word then.
  assign w_pop       = (r_state == LOAD);
  assign word_ready  = !w_full || w_pop;
  assign w_push      = word_valid && word_ready;
  assign w_next_idx  = r_byte_idx + 3'd1;

  assign TxD_start   = r_txd_start;
  assign data_out    = r_data_out;
  assign frames_sent = r_frames_sent;
  assign idle        = w_empty && (r_state == IDLE);

  nonce_word_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (w_push),
    .pop  (w_pop),
    .din  (word_in),
    .full (w_full),
    .empty(w_empty),
    .dout (w_fifo_dout)
  );

  // The start pulse is launched on entry to START so it is high for the START cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_word        <= 32'h0000_0000;
      r_byte_idx    <= 3'd0;
      r_to_cnt      <= 2'd0;
      r_txd_start   <= 1'b0;
      r_data_out    <= 8'h00;
      r_frames_sent <= 16'h0000;
    end else begin
      r_txd_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) r_state <= LOAD;
        end
        LOAD: begin
          r_word      <= w_fifo_dout;
          r_byte_idx  <= 3'd0;
          r_data_out  <= frame_byte(w_fifo_dout, 3'd0, SYNC_BYTE);
          r_txd_start <= !TxD_busy;
          r_state     <= START;
        end
        START: begin
          r_to_cnt <= 2'd0;
          if (r_txd_start) begin
            r_state <= WAIT_HI;
          end else if (!TxD_busy) begin
            r_txd_start <= 1'b1;
          end
        end
        WAIT_HI: begin
          if (TxD_busy) begin
            r_state <= WAIT_LO;
          end else if (r_to_cnt == TO_LAST) begin
            r_txd_start <= 1'b1;
            r_state     <= START;
          end else begin
            r_to_cnt <= r_to_cnt + 2'd1;
          end
        end
        WAIT_LO: begin
          if (!TxD_busy) begin
            if (r_byte_idx == LAST_IDX) begin
              r_frames_sent <= r_frames_sent + 16'd1;
              r_state       <= IDLE;
            end else begin
              r_byte_idx  <= w_next_idx;
              r_data_out  <= frame_byte(r_word, w_next_idx, SYNC_BYTE);
              r_txd_start <= 1'b1;
              r_state     <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_tx_framer.sv
// Randomized self-checking bench for nonce_tx_framer: a busy-for-10-cycles
// transmitter model, a byte-stream scoreboard and directed corner cases.
module tb_nonce_tx_framer;
  localparam int         TX_HOLD = 10;
  localparam logic [7:0] SYNC    = 8'hA5;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int FB = 6;
`else
  localparam int FB = 5;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] word_in;
  logic        word_valid;
  logic        word_ready;
  logic        TxD_start;
  logic [7:0]  data_out;
  logic        TxD_busy;
  logic        idle;
  logic [15:0] frames_sent;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  int          pulse_cyc_q[$];
  logic [15:0] exp_frames = 16'h0000;
  int          accept_cyc = 0;

  int          tx_left = 0;
  bit          tx_pend = 1'b0;
  bit          stall = 1'b0;
  bit          busy_prev;
  int          ignore_n = 0;
  bit          retry_pending = 1'b0;
  int          n_retries = 0;
  int          n_pulses = 0;
  logic [7:0]  ignored_byte;
  int          ignored_cyc = 0;
  logic [7:0]  tx_byte = 8'h00;
  bit          hold_valid = 1'b0;

  nonce_tx_framer #(.DEPTH(4), .SYNC_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .TxD_start  (TxD_start),
    .data_out   (data_out),
    .TxD_busy   (TxD_busy),
    .idle       (idle),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Transmitter model: busy one cycle after an accepted start, held TX_HOLD cycles.
  initial begin
    TxD_busy = 1'b0;
    forever begin
      @(negedge clk);
      busy_prev = TxD_busy;
      if (tx_left != 0) tx_left = tx_left - 1;
      if (tx_pend) begin
        tx_left = TX_HOLD;
        tx_pend = 1'b0;
      end
      TxD_busy = (tx_left != 0) || stall;
      if (TxD_start === 1'b1) begin
        n_pulses++;
        check("start_while_busy", {31'd0, busy_prev}, 32'd0);
        if (ignore_n > 0) begin
          ignore_n--;
          retry_pending = 1'b1;
          ignored_byte  = data_out;
          ignored_cyc   = cyc;
        end else begin
          if (retry_pending) begin
            check("retry_byte", {24'd0, data_out}, {24'd0, ignored_byte});
            check("retry_gap", {31'd0, (cyc - ignored_cyc >= 3) && (cyc - ignored_cyc <= 4)}, 32'd1);
            retry_pending = 1'b0;
            n_retries++;
          end
          tx_pend    = 1'b1;
          tx_byte    = data_out;
          hold_valid = 1'b1;
          rx_q.push_back(data_out);
          pulse_cyc_q.push_back(cyc);
        end
      end
      if (tx_left == 1 && hold_valid) begin
        check("data_stable", {24'd0, data_out}, {24'd0, tx_byte});
        hold_valid = 1'b0;
      end
    end
  end

  task automatic model_push(input logic [31:0] w);
    exp_q.push_back(SYNC);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
`ifdef NONCE_TX_CHECKSUM_EN
    exp_q.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
    exp_frames = exp_frames + 16'd1;
  endtask

  // Called at a negedge: presents w for one cycle and reports acceptance.
  task automatic offer(input logic [31:0] w, output bit acc);
    word_in    = w;
    word_valid = 1'b1;
    acc        = word_ready;
    if (acc) begin
      accept_cyc = cyc;
      model_push(w);
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [31:0] w, input int budget);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < budget) begin
      offer(w, acc);
      n++;
    end
    word_valid = 1'b0;
    check("send_accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (!(rx_q.size() >= exp_q.size() && idle === 1'b1 && TxD_busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, {31'd0, n < budget}, 32'd1);
    check({tag, "_nbytes"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
    check({tag, "_frames"}, {16'd0, frames_sent}, {16'd0, exp_frames});
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, {31'd0, TxD_start}, 32'd0);
    check({tag, "_data"}, {24'd0, data_out}, 32'd0);
    check({tag, "_ready"}, {31'd0, word_ready}, 32'd1);
    check({tag, "_idle"}, {31'd0, idle}, 32'd1);
    check({tag, "_frames"}, {16'd0, frames_sent}, 32'd0);
  endtask

  initial begin
    bit          acc;
    bit          acc_v [6];
    int          n_acc;
    int          n;
    int          simul_cyc;
    int          pulses0;
    int          retries0;
    logic [31:0] w;

    rst        = 1'b1;
    word_valid = 1'b0;
    word_in    = 32'h0000_0000;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single word from idle, with first-start latency.
    pulse_cyc_q.delete();
    send(32'hDEAD_BEEF, 10);
    drain("single", 1000);
    check("latency", (pulse_cyc_q.size() > 0) ? pulse_cyc_q[0] - accept_cyc : -1, 32'd3);

    // Transmitter ignores the first start: same byte is re-pulsed.
    retries0 = n_retries;
    ignore_n = 1;
    send($urandom, 10);
    drain("timeout", 1000);
    check("timeout_retries", n_retries - retries0, 32'd1);

    // Overflow with the transmitter stalled busy.
    stall = 1'b1;
    repeat (3) @(negedge clk);
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      offer(w, acc);
      acc_v[i] = acc;
      if (acc) n_acc++;
    end
    word_valid = 1'b0;
    check("ovf_accepted", n_acc, 32'd5);
    check("ovf_first_ready", {31'd0, acc_v[0]}, 32'd1);
    check("ovf_sixth_ready", {31'd0, acc_v[5]}, 32'd0);

    // Push held while full; must land in the cycle the FSM pops.
    pulse_cyc_q.delete();
    w     = $urandom;
    stall = 1'b0;
    acc   = 1'b0;
    n     = 0;
    while (!acc && n < 2000) begin
      offer(w, acc);
      n++;
    end
    word_valid = 1'b0;
    check("simul_accept", {31'd0, acc}, 32'd1);
    simul_cyc = accept_cyc;
    drain("ovf", 4000);
    check("simul_next_sync", (pulse_cyc_q.size() > FB) ? pulse_cyc_q[FB] - simul_cyc : -1, 32'd1);

    // Reset after the second byte of a frame.
    send($urandom, 10);
    n = 0;
    while (rx_q.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach", {31'd0, rx_q.size() >= 2}, 32'd1);
    rst        = 1'b1;
    hold_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    rx_q.delete();
    exp_q.delete();
    exp_frames = 16'h0000;
    pulses0    = n_pulses;
    repeat (15) @(negedge clk);
    check("rst_no_start", n_pulses - pulses0, 32'd0);
    send(32'h0000_0001, 10);
    drain("after_rst", 1000);

    // Random words, gaps and occasional ignored starts.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 3) == 0) ignore_n = 1;
      send($urandom, 2000);
    end
    drain("random", 8000);

    // frames_sent wrap.
    force dut.r_frames_sent = 16'hFFFE;
    @(negedge clk);
    release dut.r_frames_sent;
    exp_frames = 16'hFFFE;
    send($urandom, 10);
    drain("wrap_ffff", 1000);
    send($urandom, 10);
    drain("wrap_0", 1000);
    check("wrap_zero", {16'd0, frames_sent}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
